// File: rtl/updown_pkg.sv
// Shared definitions for the modulo up/down counter: direction encoding and
// the step-clamping helper used by updown_mod_counter.
package updown_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // The effective step never exceeds the modulo, so a single step can wrap at most once.
    function automatic logic [31:0] clamp_step(input logic [31:0] step, input logic [31:0] modulo);
        logic [31:0] s;
        if (step < modulo) begin
            s = step;
        end else begin
            s = modulo;
        end
        return s;
    endfunction

endpackage

// File: rtl/updown_next.sv
// Combinational next-count calculator. Wrap mode by default; saturating
// arithmetic when UPDOWN_SAT_EN is defined, where wrap flags "result at bound".
module updown_next
    import updown_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] n,
    input  logic [W-1:0] s,
    input  logic [W-1:0] modulo,
    input  logic         u,
    output logic [W-1:0] nxt,
    output logic         wrap
);

    logic [W:0] sum_s;

`ifdef UPDOWN_SAT_EN
    // Saturating next value: pin at modulo going up, at zero going down.
    always_comb begin
        sum_s = {1'b0, n} + {1'b0, s};
        nxt   = n;
        wrap  = 1'b0;
        if (u == DIR_UP) begin
            if (sum_s >= {1'b0, modulo}) begin
                nxt  = modulo;
                wrap = 1'b1;
            end else begin
                nxt  = sum_s[W-1:0];
                wrap = 1'b0;
            end
        end else begin
            if (n <= s) begin
                nxt  = '0;
                wrap = 1'b1;
            end else begin
                nxt  = n - s;
                wrap = 1'b0;
            end
        end
    end
`else
    logic [W:0] lim_s;

    // Wrapping next value; the range holds modulo+1 values, computed in W+1 bits.
    always_comb begin
        sum_s = {1'b0, n} + {1'b0, s};
        lim_s = {1'b0, modulo} + {{W{1'b0}}, 1'b1};
        nxt   = n;
        wrap  = 1'b0;
        if (u == DIR_UP) begin
            if (sum_s > {1'b0, modulo}) begin
                nxt  = W'(sum_s - lim_s);
                wrap = 1'b1;
            end else begin
                nxt  = sum_s[W-1:0];
                wrap = 1'b0;
            end
        end else begin
            if (n < s) begin
                nxt  = W'({1'b0, n} + lim_s - {1'b0, s});
                wrap = 1'b1;
            end else begin
                nxt  = n - s;
                wrap = 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo up/down counter with load, variable step and registered terminal
// count. Define UPDOWN_SAT_EN for saturating instead of wrapping behaviour.
module updown_mod_counter
    import updown_pkg::*;
#(
    parameter int W     = 4,
    parameter int SW    = 2,
    parameter int RST_V = 0
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          enable,
    input  logic          u,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic [W-1:0]  modulo,
    input  logic [SW-1:0] step,
    output logic [W-1:0]  n,
    output logic          tc
);

    localparam logic [W-1:0] RST_VAL = W'(RST_V);

    logic [W-1:0] s_s;
    logic [W-1:0] nxt_s;
    logic         wrap_s;
    logic [W-1:0] load_clip_s;
    logic [W-1:0] fix_val_s;
    logic         out_of_range_s;

    // Effective step, clipped load value and the value used to recover from an out-of-range count.
    always_comb begin
        s_s            = W'(clamp_step(32'(step), 32'(modulo)));
        out_of_range_s = (n > modulo);
        if (load_val > modulo) begin
            load_clip_s = modulo;
        end else begin
            load_clip_s = load_val;
        end
`ifdef UPDOWN_SAT_EN
        fix_val_s = modulo;
`else
        fix_val_s = '0;
`endif
    end

    updown_next #(
        .W (W)
    ) u_next (
        .n      (n),
        .s      (s_s),
        .modulo (modulo),
        .u      (u),
        .nxt    (nxt_s),
        .wrap   (wrap_s)
    );

    // Count and terminal-count registers: clr > load > range fix > enabled count > hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            n  <= RST_VAL;
            tc <= 1'b0;
        end else if (load) begin
            n  <= load_clip_s;
            tc <= 1'b0;
        end else if (out_of_range_s) begin
            n  <= fix_val_s;
            tc <= 1'b0;
        end else if (enable) begin
            if (modulo == '0) begin
                n  <= n;
                tc <= 1'b1;
            end else if (s_s == '0) begin
                n  <= n;
                tc <= 1'b0;
            end else begin
                n  <= nxt_s;
                tc <= wrap_s;
            end
        end else begin
            n  <= n;
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_updown_mod_counter;

    localparam int W     = 4;
    localparam int SW    = 2;
    localparam int RST_V = 0;
`ifdef UPDOWN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          enable = 1'b0;
    logic          u = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = 4'd0;
    logic [W-1:0]  modulo = 4'd9;
    logic [SW-1:0] step = 2'd1;
    logic [W-1:0]  n;
    logic          tc;

    int checks = 0;
    int passes = 0;
    int mn = 0;
    bit mtc = 1'b0;
    bit mvalid = 1'b0;

    updown_mod_counter #(.W(W), .SW(SW), .RST_V(RST_V)) dut (
        .clk      (clk),
        .clr      (clr),
        .enable   (enable),
        .u        (u),
        .load     (load),
        .load_val (load_val),
        .modulo   (modulo),
        .step     (step),
        .n        (n),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    // Reference model: modular / clamped arithmetic on plain integers.
    always @(posedge clk) begin : model
        int m;
        int s;
        int nn;
        bit t;
        m  = int'(modulo);
        s  = (int'(step) < m) ? int'(step) : m;
        nn = mn;
        t  = 1'b0;
        if (clr) begin
            nn = RST_V;
        end else if (load) begin
            nn = (int'(load_val) > m) ? m : int'(load_val);
        end else if (mn > m) begin
            nn = SAT ? m : 0;
        end else if (enable) begin
            if (m == 0) begin
                t = 1'b1;
            end else if (s != 0) begin
                if (SAT) begin
                    if (u) begin
                        nn = (mn + s > m) ? m : mn + s;
                        t  = (nn == m);
                    end else begin
                        nn = (mn - s < 0) ? 0 : mn - s;
                        t  = (nn == 0);
                    end
                end else begin
                    if (u) begin
                        t  = (mn + s > m);
                        nn = (mn + s) % (m + 1);
                    end else begin
                        t  = (mn < s);
                        nn = (mn - s + m + 1) % (m + 1);
                    end
                end
            end
        end
        mn  <= nn;
        mtc <= t;
        if (clr) mvalid <= 1'b1;
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (mvalid) begin
            checks = checks + 1;
            if (n === W'(mn) && tc === mtc) begin
                passes = passes + 1;
            end else begin
                $display("FAIL model t=%0t: n=%0d tc=%0b, expected n=%0d tc=%0b",
                         $time, n, tc, mn, mtc);
            end
        end
    end

    task automatic drive(input logic c, input logic ld, input logic [W-1:0] lv,
                         input logic [W-1:0] mo, input logic en, input logic uu,
                         input logic [SW-1:0] st);
        @(negedge clk);
        clr = c; load = ld; load_val = lv; modulo = mo; enable = en; u = uu; step = st;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int en, input bit et);
        checks = checks + 1;
        if (n === W'(en) && tc === et) begin
            passes = passes + 1;
        end else begin
            $display("FAIL %s: n=%0d tc=%0b, expected n=%0d tc=%0b", name, n, tc, en, et);
        end
    endtask

    initial begin
        // Reset held two cycles.
        drive(1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 2'd1); lit("reset1", 0, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 2'd1); lit("reset2", 0, 1'b0);
`ifndef UPDOWN_SAT_EN
        // Count up through modulo 9 and wrap.
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 2'd1);
            lit("up_mod9", (i + 1) % 10, i == 9);
        end
        // Down wrap from 0 with modulo 15.
        drive(1'b1, 1'b0, 4'd0, 4'd15, 1'b0, 1'b0, 2'd1); lit("clr_b", 0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd15, 1'b1, 1'b0, 2'd1); lit("down_wrap", 15, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 4'd15, 1'b1, 1'b0, 2'd1); lit("down_14", 14, 1'b0);
        // Step 3 wrap and step 0 hold.
        drive(1'b0, 1'b1, 4'd8, 4'd9, 1'b0, 1'b1, 2'd3); lit("load8", 8, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 2'd3); lit("step3_wrap", 1, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 2'd0); lit("step0_hold", 1, 1'b0);
        // Load clipped to modulo beats enable; then modulo lowered below n.
        drive(1'b0, 1'b1, 4'd12, 4'd9, 1'b1, 1'b1, 2'd1); lit("load_clip", 9, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1, 2'd1); lit("oor_fix", 0, 1'b0);
        // Clear mid-count overrides load.
        drive(1'b0, 1'b1, 4'd6, 4'd9, 1'b0, 1'b1, 2'd1); lit("load6", 6, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 2'd1); lit("up_7", 7, 1'b0);
        drive(1'b1, 1'b1, 4'd3, 4'd9, 1'b1, 1'b1, 2'd1); lit("clr_over_load", 0, 1'b0);
        // Down wrap with step 3, clamped step, enable low, modulo 0.
        drive(1'b0, 1'b1, 4'd1, 4'd9, 1'b0, 1'b0, 2'd3); lit("load1", 1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0, 2'd3); lit("down3_wrap", 8, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 2'd3); lit("en_low", 8, 1'b0);
        drive(1'b0, 1'b1, 4'd1, 4'd2, 1'b0, 1'b1, 2'd3); lit("load1_m2", 1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b1, 2'd3); lit("clamp_wrap", 0, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'd1); lit("mod0_a", 0, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 2'd2); lit("mod0_b", 0, 1'b1);
`else
        // Saturating: pinned at modulo with tc every enabled cycle.
        drive(1'b0, 1'b1, 4'd8, 4'd9, 1'b0, 1'b1, 2'd3); lit("load8", 8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 2'd3);
            lit("sat_up", 9, 1'b1);
        end
        drive(1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1, 2'd1); lit("oor_sat", 5, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd5, 1'b1, 1'b0, 2'd3); lit("sat_dn_2", 2, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd5, 1'b1, 1'b0, 2'd3); lit("sat_dn_0", 0, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 4'd5, 1'b1, 1'b0, 2'd3); lit("sat_dn_pin", 0, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0, 2'd3); lit("en_low", 0, 1'b0);
`endif
        drive(1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
